trace_display_driver: RTL and testbench
=======================================

Name: trace_display_driver

Overview:
- Sits directly downstream of the processor top and consumes its two observation outputs: the current fetch PC and the writeback data.
- Captures one of the two values under a hold control and time-multiplexes it as 8 hex digits onto the board's common-anode seven-segment display.
- Operates in the processor's clock domain and is instantiated beside the processor in the board-level wrapper.

Parameters:
REFRESH_COUNT, 100000, clock cycles each digit stays lit before the scan advances (>=2)

Ports:
Clock  input  1  system clock; all logic is rising-edge
Reset  input  1  synchronous, active-high reset
PC_In  input  32  processor fetch PC (PC_To_Instr_Mem_output)
WriteData_In  input  32  processor writeback data (regWriteData_output)
Sel  input  1  0 = display PC, 1 = display write data
Hold  input  1  1 = freeze captured values
Anode  output  8  digit enables, active-low; bit i = digit i (digit 0 rightmost)
Segments  output  7  {g,f,e,d,c,b,a}, active-low
DP  output  1  decimal point, active-low

Behaviour:
- One clock and one reset. Reset is synchronous and active-high. Every register below is updated only on the rising edge of Clock.
- Capture registers Cap_PC and Cap_WD (32b each):
  - Reset value: 0.
  - When Hold=0, each cycle: Cap_PC <= PC_In and Cap_WD <= WriteData_In.
  - When Hold=1, both registers keep their value.
  - Hold affects only the capture registers. Scanning continues while Hold=1.
- Sel_q register:
  - Reset value: 0.
  - Sel_q <= Sel every cycle, independent of Hold.
- Shown value: Cap_WD when Sel_q=1, otherwise Cap_PC.
- Refresh counter Ref_Cnt (width = clog2(REFRESH_COUNT)):
  - Reset value: 0.
  - Increments each cycle.
  - When Ref_Cnt = REFRESH_COUNT-1, it wraps to 0 and Digit_Idx advances.
- Digit index Digit_Idx (3b):
  - Reset value: 0.
  - Advances by 1 on each refresh wrap, wrapping from 7 to 0.
- Outputs are registered, so they show the current Digit_Idx and shown value one cycle later:
  - Anode <= ~(8'b1 << Digit_Idx), so exactly one bit is low.
  - Segments <= decode(shown value[4*Digit_Idx+3 : 4*Digit_Idx]).
  - DP <= 0 only when Sel_q=1 and Digit_Idx=0; otherwise 1.
- Reset output values: Anode=8'hFF, Segments=7'h7F, DP=1 (display fully dark).
- Decode, hex nibble -> Segments:
  - 0->40, 1->79, 2->24, 3->30, 4->19, 5->12, 6->02, 7->78
  - 8->00, 9->10, A->08, b->03, C->46, d->21, E->06, F->0E
- Latency:
  - An input change appears on Segments no earlier than 2 cycles later (capture, then output register), and only while its digit is selected.
  - A Sel change takes effect on Segments 2 cycles later, on the digit currently being scanned.
- Boundary conditions:
  - Reset asserted mid-scan: on that edge all registers return to reset values. The first non-reset edge then gives Anode=FE.
  - Reset has priority over Hold.
  - Hold and Sel changing in the same cycle: each acts independently.
  - Digit 7 -> 0 wrap: no blank cycle between digits.

Test Plan (REFRESH_COUNT=4):
1. Reset for 2 cycles -> Anode=FF, Segments=7F, DP=1. First cycle after release: Anode=FE, Segments=40 (digit 0 of zero).
2. Hold=0, Sel=0, PC_In=0x0040_00AC -> digit 0 shows C (46), digit 1 shows A (08), digit 2 shows 0 (40), digit 6 shows 4 (19). Each Anode value lasts exactly 4 cycles; the sequence is FE, FD, FB, ..., 7F, FE.
3. Sel=1, WriteData_In=0xDEAD_BEEF -> digit 0 shows F (0E) with DP=0; digit 7 shows d (21) with DP=1.
4. Hold=1 with PC_In=0x1234_5678 captured, then PC_In changes to 0 -> the full 8-digit scan still shows 8,7,6,5,4,3,2,1 (00,78,02,12,19,30,24,79). Release Hold -> zeros appear within 2 cycles.
5. Reset asserted on the third cycle of digit 5 -> next edge Anode=FF and Segments=7F. After release the scan restarts at digit 0 with Ref_Cnt=0.

Source files
------------

// File: rtl/trace_display_driver.sv
// Captures the processor's fetch PC or writeback data and scans it as eight
// hex digits onto a common-anode seven-segment display (all outputs active-low).
module trace_display_driver #(
  parameter int REFRESH_COUNT = 100000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] PC_In,
  input  logic [31:0] WriteData_In,
  input  logic        Sel,
  input  logic        Hold,
  output logic [7:0]  Anode,
  output logic [6:0]  Segments,
  output logic        DP
);

  localparam int CNT_W = (REFRESH_COUNT > 1) ? $clog2(REFRESH_COUNT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_COUNT - 1);

  logic [31:0]      cap_pc;
  logic [31:0]      cap_wd;
  logic             sel_q;
  logic [CNT_W-1:0] ref_cnt;
  logic [2:0]       digit_idx;

  logic [31:0]      shown;
  logic [3:0]       nibble;

  // Common-anode patterns {g,f,e,d,c,b,a}: a 0 lights the segment.
  function automatic logic [6:0] decode(input logic [3:0] hex);
    logic [6:0] seg;
    case (hex)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

  // NOTE: every signal written in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    shown  = sel_q ? cap_wd : cap_pc;
    nibble = shown[{digit_idx, 2'b00} +: 4];
  end

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      cap_pc    <= '0;
      cap_wd    <= '0;
      sel_q     <= 1'b0;
      ref_cnt   <= '0;
      digit_idx <= '0;
      Anode     <= 8'hFF;
      Segments  <= 7'h7F;
      DP        <= 1'b1;
    end else begin
      if (!Hold) begin
        cap_pc <= PC_In;
        cap_wd <= WriteData_In;
      end
      sel_q <= Sel;

      if (ref_cnt == CNT_MAX) begin
        ref_cnt   <= '0;
        digit_idx <= digit_idx + 3'd1;
      end else begin
        ref_cnt <= ref_cnt + CNT_W'(1);
      end

      // Outputs reflect the digit selected before this edge, one cycle behind the scan.
      Anode    <= ~(8'b1 << digit_idx);
      Segments <= decode(nibble);
      DP       <= ~(sel_q && (digit_idx == 3'd0));
    end
  end

endmodule

// File: tb/tb_trace_display_driver.sv
// Self-checking bench for trace_display_driver: directed scenarios followed by
// randomized traffic, compared each cycle against a cycle-count based model.
module tb_trace_display_driver;

  localparam int R = 4;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] PC_In = '0;
  logic [31:0] WriteData_In = '0;
  logic        Sel = 1'b0;
  logic        Hold = 1'b0;
  logic [7:0]  Anode;
  logic [6:0]  Segments;
  logic        DP;

  int errors = 0;
  int checks = 0;

  trace_display_driver #(.REFRESH_COUNT(R)) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .PC_In        (PC_In),
    .WriteData_In (WriteData_In),
    .Sel          (Sel),
    .Hold         (Hold),
    .Anode        (Anode),
    .Segments     (Segments),
    .DP           (DP)
  );

  always #5 Clock = ~Clock;

  // Hex nibble to active-low segment pattern.
  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model state: captured values, registered select, and edges since reset release.
  logic [31:0] m_pc = '0;
  logic [31:0] m_wd = '0;
  logic        m_sel = 1'b0;
  int          m_n = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock edge: predict outputs from the pre-edge model, then advance the model.
  task automatic step();
    logic [7:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    int          d;
    logic [31:0] v;
    if (Reset) begin
      e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1;
    end else begin
      d     = (m_n / R) % 8;
      v     = m_sel ? m_wd : m_pc;
      e_an  = ~(8'(1) << d);
      e_seg = seg_tab[(v >> (4 * d)) & 32'hF];
      e_dp  = (m_sel && d == 0) ? 1'b0 : 1'b1;
    end
    @(posedge Clock);
    #1;
    check("anode", 32'(Anode), 32'(e_an));
    check("segments", 32'(Segments), 32'(e_seg));
    check("dp", 32'(DP), 32'(e_dp));
    if (Reset) begin
      m_pc = '0; m_wd = '0; m_sel = 1'b0; m_n = 0;
    end else begin
      if (!Hold) begin
        m_pc = PC_In;
        m_wd = WriteData_In;
      end
      m_sel = Sel;
      m_n++;
    end
  endtask

  initial begin
    // 1. Reset for two cycles, then release.
    Reset = 1'b1;
    step(); step();
    check("reset_anode_literal", 32'(Anode), 32'hFF);
    Reset = 1'b0;
    step();
    check("first_anode_literal", 32'(Anode), 32'hFE);
    check("first_seg_literal", 32'(Segments), 32'h40);

    // 2. PC display across more than a full scan, including the 7 -> 0 wrap.
    PC_In = 32'h0040_00AC; Sel = 1'b0; Hold = 1'b0;
    for (int i = 0; i < 40; i++) step();

    // 3. Write-data display with the decimal point on digit 0.
    Sel = 1'b1; WriteData_In = 32'hDEAD_BEEF;
    for (int i = 0; i < 36; i++) step();

    // 4. Hold freezes the captured PC while the scan keeps running.
    Sel = 1'b0; PC_In = 32'h1234_5678;
    step(); step();
    Hold = 1'b1; PC_In = 32'h0;
    for (int i = 0; i < 34; i++) step();
    Hold = 1'b0;
    for (int i = 0; i < 6; i++) step();

    // Hold and Sel change together.
    PC_In = 32'hCAFE_F00D; WriteData_In = 32'h0123_4567;
    step();
    Hold = 1'b1; Sel = 1'b1; PC_In = 32'h0; WriteData_In = 32'hFFFF_FFFF;
    for (int i = 0; i < 34; i++) step();
    Hold = 1'b0; Sel = 1'b0;

    // 5. Reset on the third cycle of digit 5, with Hold asserted to show reset priority.
    Reset = 1'b1; step(); Reset = 1'b0;
    PC_In = 32'h89AB_CDEF;
    while (m_n != 5 * R + 2) step();
    Hold = 1'b1;
    Reset = 1'b1;
    step();
    check("midscan_reset_anode", 32'(Anode), 32'hFF);
    check("midscan_reset_seg", 32'(Segments), 32'h7F);
    Reset = 1'b0;
    step();
    check("restart_anode", 32'(Anode), 32'hFE);
    for (int i = 0; i < 10; i++) step();
    Hold = 1'b0;

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      PC_In        = $urandom;
      WriteData_In = $urandom;
      if ($urandom_range(0, 3) == 0) Sel  = 1'($urandom);
      if ($urandom_range(0, 3) == 0) Hold = 1'($urandom);
      Reset = ($urandom_range(0, 99) == 0);
      step();
    end
    Reset = 1'b0;
    for (int i = 0; i < 8; i++) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
